div_seq: RTL and testbench

Iterative radix-2 divider and its sequencing controller for the RISC-V M-extension divide/remainder instructions (DIV, DIVU, REM, REMU). The EX stage issues one request with a start pulse. The block holds `busy` for the pipeline's stall logic, runs one quotient bit per cycle, and returns the result with a one-cycle `done` pulse. Divide-by-zero and signed overflow bypass the iteration loop and complete in one cycle.

---
 rtl/div_seq_if.sv | 25 ++
 rtl/div_seq.sv | 155 +++++++++++++++
 tb/tb_div_seq.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// The EX stage is the master: it drives the request and the kill, and reads
// back the stall, the completion pulse and the result.
interface div_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle over XLEN cycles. Divide-by-zero and signed
// overflow finish at accept time and skip the loop. busy/done/result all
// come straight from flops.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  div_seq_if.slave  bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;      // partial remainder
  logic [XLEN-1:0] quo_q, quo_d;      // dividend shifting out / quotient shifting in
  logic [XLEN-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [XLEN-1:0] res_q, res_d;      // presented result, held between dones
  logic [CW-1:0]   cnt_q, cnt_d;      // remaining iterations
  logic            want_rem_q, want_rem_d;
  logic            qneg_q, qneg_d;    // quotient must be negated at the end
  logic            rneg_q, rneg_d;    // remainder must be negated at the end

  // Request decode, evaluated every cycle against the live inputs.
  logic            sgn_in;
  logic            accept;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] special_res;

  assign sgn_in   = ~bus.funct3[0];
  // A start while iterating is dropped rather than queued; flush kills it too.
  assign accept   = bus.start & bus.funct3[2] & ~bus.flush & (state_q != S_CALC);
  assign div_zero = (bus.b == '0);
  assign ovf      = sgn_in & (bus.a == MIN_NEG) & (bus.b == '1);
  assign a_abs    = (sgn_in & bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign b_abs    = (sgn_in & bus.b[XLEN-1]) ? -bus.b : bus.b;

  // Divide-by-zero follows the RISC-V rules (q = -1, r = a, raw and unsigned-
  // agnostic); overflow returns the most negative value with a zero remainder.
  assign special_res = div_zero ? (bus.funct3[1] ? bus.a : '1)
                                : (bus.funct3[1] ? '0    : MIN_NEG);

  // One restoring step. The shifted remainder can need XLEN+1 bits when the
  // divisor sits in the top half of the range, so the trial subtract is one bit
  // wider and its top bit doubles as the borrow.
  logic [XLEN:0]   shl;
  logic [XLEN:0]   diff;
  logic            take;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] fin_res;

  assign shl     = {rem_q, quo_q[XLEN-1]};
  assign diff    = shl - {1'b0, dvs_q};
  assign take    = ~diff[XLEN];
  assign rem_n   = take ? diff[XLEN-1:0] : shl[XLEN-1:0];
  assign quo_n   = {quo_q[XLEN-2:0], take};
  assign fin_res = want_rem_q ? (rneg_q ? -rem_n : rem_n)
                              : (qneg_q ? -quo_n : quo_n);

  // Next-state and datapath update; everything holds unless a case moves it.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    want_rem_d = want_rem_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;

    if (bus.flush) begin
      // Killed op leaves result untouched and never pulses done.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (accept) begin
            want_rem_d = bus.funct3[1];
            qneg_d     = sgn_in & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            rneg_d     = sgn_in & bus.a[XLEN-1];
            rem_d      = '0;
            quo_d      = a_abs;
            dvs_d      = b_abs;
            cnt_d      = CW'(XLEN);
            if (div_zero | ovf) begin
              state_d = S_DONE;
              res_d   = special_res;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            res_d   = fin_res;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset clears everything at once, even mid-op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      want_rem_q <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      want_rem_q <= want_rem_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
    end
  end

  // Outputs decode directly from flops, so no input reaches them combinationally.
  assign bus.busy   = (state_q == S_CALC);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;

  // Stall and completion are mutually exclusive by construction.
  a_busy_done_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.busy && bus.done));

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: expected results are queued at issue and
// popped when done pulses; cycle-accurate busy/done windows are checked inline.
module tb_div_seq;
  localparam int XLEN = 32;

  typedef struct {
    logic [2:0]      f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_seq_if #(.XLEN(XLEN)) dif ();

  div_seq #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] sb[$];
  logic [XLEN-1:0] last_res;
  int n_vec = 0;
  int n_err = 0;

  // Reference model for randomly generated operands.
  function automatic logic [XLEN-1:0] model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic sgn;
    logic rem;
    sgn = ~f[0];
    rem = f[1];
    if (b == 0) return rem ? a : '1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  // Advance to the sampling point one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an accepted request for one cycle and queue its expected result.
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    dif.start  = 1'b1;
    dif.funct3 = f;
    dif.a      = a;
    dif.b      = b;
    sb.push_back(exp);
    step();
    dif.start  = 1'b0;
  endtask

  task automatic test_reset();
    dif.start = 0; dif.funct3 = 0; dif.a = 0; dif.b = 0; dif.flush = 0;
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.result !== '0) begin
      n_err++;
      $display("FAIL reset_state busy=%b done=%b result=%h required 0/0/0", dif.busy, dif.done, dif.result);
    end
    #3 rst = 1'b0;
    step();
    last_res = '0;
  endtask

  task automatic test_normal();
    op_t ops[$];
    logic bad;
    logic [XLEN-1:0] e;
    ops.push_back('{3'b100, 32'd100, 32'd7, 32'd14});
    ops.push_back('{3'b110, 32'd100, 32'd7, 32'd2});
    ops.push_back('{3'b100, -32'sd100, 32'd7, 32'hFFFF_FFF2});
    ops.push_back('{3'b110, -32'sd7, 32'd2, 32'hFFFF_FFFF});
    ops.push_back('{3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1});
    ops.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF});
    ops.push_back('{3'b101, 32'h8000_0000, 32'h9000_0001, 32'd0});
    for (int i = 0; i < 4; i++) begin
      op_t o;
      o.f = {1'b1, 2'($urandom_range(0, 3))};
      o.a = $urandom;
      o.b = $urandom >> $urandom_range(0, 28);
      if (o.b == 0) o.b = 32'd3;
      o.exp = model(o.f, o.a, o.b);
      ops.push_back(o);
    end
    foreach (ops[k]) begin
      issue(ops[k].f, ops[k].a, ops[k].b, ops[k].exp);
      bad = 1'b0;
      for (int c = 1; c <= 32; c++) begin
        if (dif.busy !== 1'b1 || dif.done !== 1'b0) bad = 1'b1;
        step();
      end
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL normal_busy_window op%0d busy/done wrong within cycles 1..32, required busy=1 done=0", k);
      end
      e = sb.pop_front();
      n_vec++;
      if (dif.done !== 1'b1 || dif.busy !== 1'b0 || dif.result !== e) begin
        n_err++;
        $display("FAIL normal_result op%0d done=%b busy=%b result=%h required done=1 busy=0 result=%h",
                 k, dif.done, dif.busy, dif.result, e);
      end
      last_res = e;
      step();
      n_vec++;
      if (dif.done !== 1'b0 || dif.result !== e) begin
        n_err++;
        $display("FAIL normal_done_single op%0d done=%b result=%h required done=0 result=%h", k, dif.done, dif.result, e);
      end
    end
  endtask

  task automatic test_special();
    op_t ops[$];
    logic [XLEN-1:0] e;
    ops.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF});
    ops.push_back('{3'b110, 32'd5, 32'd0, 32'd5});
    ops.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    ops.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    foreach (ops[k]) begin
      issue(ops[k].f, ops[k].a, ops[k].b, ops[k].exp);
      e = sb.pop_front();
      n_vec++;
      if (dif.done !== 1'b1 || dif.busy !== 1'b0 || dif.result !== e) begin
        n_err++;
        $display("FAIL special_result op%0d done=%b busy=%b result=%h required done=1 busy=0 result=%h",
                 k, dif.done, dif.busy, dif.result, e);
      end
      last_res = e;
      step();
      n_vec++;
      if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin
        n_err++;
        $display("FAIL special_after op%0d done=%b busy=%b required 0/0", k, dif.done, dif.busy);
      end
    end
  endtask

  task automatic test_ignore();
    // funct3[2]=0 is not a divide, and flush beats a simultaneous start.
    dif.start = 1'b1; dif.funct3 = 3'b000; dif.a = 32'd100; dif.b = 32'd7;
    step();
    dif.start = 1'b0;
    n_vec++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_mul_funct busy=%b done=%b required 0/0", dif.busy, dif.done);
    end
    dif.start = 1'b1; dif.funct3 = 3'b101; dif.a = 32'd5; dif.b = 32'd0; dif.flush = 1'b1;
    step();
    dif.start = 1'b0; dif.flush = 1'b0;
    n_vec++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.result !== last_res) begin
      n_err++;
      $display("FAIL flush_start_same busy=%b done=%b result=%h required 0/0/%h", dif.busy, dif.done, dif.result, last_res);
    end
  endtask

  task automatic test_flush();
    logic bad;
    logic [XLEN-1:0] e;
    issue(3'b100, 32'd100, 32'd7, 32'd14);
    for (int c = 1; c < 10; c++) step();
    dif.flush = 1'b1;               // cycle 10
    step();
    dif.flush = 1'b0;               // cycle 11
    void'(sb.pop_back());
    n_vec++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.result !== last_res) begin
      n_err++;
      $display("FAIL flush_kill busy=%b done=%b result=%h required 0/0/%h", dif.busy, dif.done, dif.result, last_res);
    end
    issue(3'b100, 32'd9, 32'd3, 32'd3);
    bad = 1'b0;
    for (int c = 12; c <= 43; c++) begin
      if (dif.busy !== 1'b1 || dif.done !== 1'b0) bad = 1'b1;
      step();
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL flush_next_busy busy/done wrong within cycles 12..43, required busy=1 done=0");
    end
    e = sb.pop_front();
    n_vec++;
    if (dif.done !== 1'b1 || dif.result !== e) begin
      n_err++;
      $display("FAIL flush_next_result cycle44 done=%b result=%h required 1/%h", dif.done, dif.result, e);
    end
    last_res = e;
    step();
  endtask

  task automatic test_back_to_back();
    logic bad;
    logic [XLEN-1:0] e;
    issue(3'b100, 32'd100, 32'd7, 32'd14);
    bad = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (dif.busy !== 1'b1 || dif.done !== 1'b0) bad = 1'b1;
      // A start in the middle of CALC must be ignored (nothing queued for it).
      if (c == 5) begin dif.start = 1'b1; dif.funct3 = 3'b101; dif.a = 32'd1; dif.b = 32'd1; end
      if (c == 6) dif.start = 1'b0;
      step();
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL b2b_first_busy busy/done wrong within cycles 1..32, required busy=1 done=0");
    end
    e = sb.pop_front();
    n_vec++;
    if (dif.done !== 1'b1 || dif.result !== e) begin
      n_err++;
      $display("FAIL b2b_first_result done=%b result=%h required 1/%h", dif.done, dif.result, e);
    end
    issue(3'b101, 32'd50, 32'd5, 32'd10);
    bad = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (dif.busy !== 1'b1 || dif.done !== 1'b0) bad = 1'b1;
      step();
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL b2b_second_busy busy/done wrong within cycles 1..32 after DONE-cycle start");
    end
    e = sb.pop_front();
    n_vec++;
    if (dif.done !== 1'b1 || dif.result !== e) begin
      n_err++;
      $display("FAIL b2b_second_result done=%b result=%h required 1/%h", dif.done, dif.result, e);
    end
    // Chain two special cases, each started in the previous DONE cycle.
    issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    e = sb.pop_front();
    n_vec++;
    if (dif.done !== 1'b1 || dif.busy !== 1'b0 || dif.result !== e) begin
      n_err++;
      $display("FAIL b2b_special1 done=%b busy=%b result=%h required 1/0/%h", dif.done, dif.busy, dif.result, e);
    end
    issue(3'b110, 32'd5, 32'd0, 32'd5);
    e = sb.pop_front();
    n_vec++;
    if (dif.done !== 1'b1 || dif.busy !== 1'b0 || dif.result !== e) begin
      n_err++;
      $display("FAIL b2b_special2 done=%b busy=%b result=%h required 1/0/%h", dif.done, dif.busy, dif.result, e);
    end
    last_res = e;
    step();
    n_vec++;
    if (dif.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end_done done=%b required 0", dif.done);
    end
  endtask

  task automatic test_rst_mid();
    logic bad;
    logic [XLEN-1:0] e;
    issue(3'b100, 32'd100, 32'd7, 32'd14);
    for (int c = 1; c < 10; c++) step();
    #1 rst = 1'b1;
    #1;
    void'(sb.pop_back());
    n_vec++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.result !== '0) begin
      n_err++;
      $display("FAIL rst_mid_calc busy=%b done=%b result=%h required 0/0/0", dif.busy, dif.done, dif.result);
    end
    #2 rst = 1'b0;
    step();
    issue(3'b100, 32'd6, 32'd3, 32'd2);
    bad = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (dif.busy !== 1'b1 || dif.done !== 1'b0) bad = 1'b1;
      step();
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL rst_after_busy busy/done wrong within cycles 1..32 after reset");
    end
    e = sb.pop_front();
    n_vec++;
    if (dif.done !== 1'b1 || dif.result !== e) begin
      n_err++;
      $display("FAIL rst_after_result done=%b result=%h required 1/%h", dif.done, dif.result, e);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_ignore();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain %0d results never produced, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
